// File: rtl/drbg_word_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : drbg_word_serializer                                            |
// | Purpose  : Prefetches DRBG generator words into a small FIFO and presents  |
// |            them slice by slice, LSB slice first, with optional line-key    |
// |            capture on H rising (enabled by macro DRBG_SER_LINE_KEY_EN).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module drbg_word_serializer #(
  parameter int DATA_WIDTH_IN  = 256,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int DEPTH          = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      H,
  input  logic                      V,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      data_in_valid,
  input  logic                      generator_busy,
  output logic                      need_next,
  input  logic                      take,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      data_out_valid,
  output logic [DATA_WIDTH_OUT-1:0] line_key,
  output logic                      underflow
);

  localparam int c_SLICES = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int c_IDX_W  = (c_SLICES > 1) ? $clog2(c_SLICES) : 1;
  localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(DEPTH + 1);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_SLICES - 1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

`ifdef DRBG_SER_LINE_KEY_EN
  localparam logic c_LINE_KEY_EN = 1'b1;
`else
  localparam logic c_LINE_KEY_EN = 1'b0;
`endif

  logic [DATA_WIDTH_IN-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_CNT_W-1:0]        r_count;
  logic [c_IDX_W-1:0]        r_idx;
  logic                      r_outstanding;
  logic                      r_discard;
  logic                      r_need_next;
  logic                      r_h;
  logic                      r_v;
  logic                      r_underflow;
  logic [DATA_WIDTH_OUT-1:0] r_line_key;

  logic                      w_valid;
  logic                      w_v_rise;
  logic                      w_h_rise;
  logic                      w_adv;
  logic                      w_last;
  logic                      w_pop;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_issue;
  logic [c_PTR_W-1:0]        w_rd_next;
  logic [c_PTR_W-1:0]        w_wr_next;
  logic [DATA_WIDTH_IN-1:0]  w_head;

  assign w_valid  = (r_count != '0);
  assign w_v_rise = V & ~r_v;
  // Field flush outranks line start, so a coincident H edge never captures.
  assign w_h_rise = c_LINE_KEY_EN & H & ~r_h & ~w_v_rise;

  // take and line start share one advance; a slice never steps twice per cycle.
  assign w_adv    = (take | w_h_rise) & w_valid & ~w_v_rise;
  assign w_last   = (r_idx == c_LAST_IDX);
  assign w_pop    = w_adv & w_last;

  // Words only count when a request is outstanding; stale ones are dropped here.
  assign w_accept = data_in_valid & r_outstanding;
  assign w_push   = w_accept & ~r_discard & ~w_v_rise;
  assign w_issue  = ~r_outstanding & ~generator_busy & ~w_v_rise & (r_count < c_DEPTH_CNT);

  assign w_rd_next = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_next = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;

  assign w_head         = r_mem[r_rd_ptr];
  assign data_out       = w_valid ? w_head[r_idx*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] : '0;
  assign data_out_valid = w_valid;
  assign need_next      = r_need_next;
  assign line_key       = r_line_key;
  assign underflow      = r_underflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_idx         <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_need_next   <= 1'b0;
      r_h           <= 1'b0;
      r_v           <= 1'b0;
      r_underflow   <= 1'b0;
      r_line_key    <= '0;
    end else begin
      r_h         <= H;
      r_v         <= V;
      r_need_next <= w_issue;

      if (take & ~w_valid) begin
        r_underflow <= 1'b1;
      end

      if (w_h_rise) begin
        r_line_key <= data_out;
      end

      if (w_v_rise) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_idx    <= '0;
      end else begin
        if (w_adv) begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= w_rd_next;
        end
        if (w_push) begin
          r_wr_ptr <= w_wr_next;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end

      if (w_issue) begin
        r_outstanding <= 1'b1;
      end else if (w_accept) begin
        r_outstanding <= 1'b0;
      end

      // A request in flight across a flush must not refill the new field.
      if (w_accept) begin
        r_discard <= 1'b0;
      end else if (w_v_rise & r_outstanding) begin
        r_discard <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_drbg_word_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_drbg_word_serializer                                         |
// | Purpose  : Table vectors, directed corner sequences and randomized traffic |
// |            against a byte-queue reference model.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_drbg_word_serializer;

  localparam int c_DW_IN  = 256;
  localparam int c_DW_OUT = 8;
  localparam int c_DEPTH  = 2;
  localparam int c_NBYTES = c_DW_IN / c_DW_OUT;

  logic                clk = 1'b0;
  logic                reset;
  logic                H, V;
  logic [c_DW_IN-1:0]  data_in;
  logic                data_in_valid;
  logic                generator_busy;
  logic                need_next;
  logic                take;
  logic [c_DW_OUT-1:0] data_out;
  logic                data_out_valid;
  logic [c_DW_OUT-1:0] line_key;
  logic                underflow;

  always #5 clk = ~clk;

  drbg_word_serializer #(
    .DATA_WIDTH_IN (c_DW_IN),
    .DATA_WIDTH_OUT(c_DW_OUT),
    .DEPTH         (c_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .H             (H),
    .V             (V),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .generator_busy(generator_busy),
    .need_next     (need_next),
    .take          (take),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .line_key      (line_key),
    .underflow     (underflow)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Reference model: the buffered stream is a plain queue of unread bytes.
  logic [7:0] mq[$];
  bit         m_out, m_disc, m_need, m_uf, m_hp, m_vp;
  logic [7:0] m_key;

  function automatic void model_reset();
    mq.delete();
    m_out = 0; m_disc = 0; m_need = 0; m_uf = 0; m_hp = 0; m_vp = 0;
    m_key = 8'h00;
  endfunction

  function automatic void model_step(bit busy, bit tk, bit h, bit v, bit dv, logic [c_DW_IN-1:0] din);
    int words;
    bit avail, vrise, hrise, issue;
    words = (mq.size() + c_NBYTES - 1) / c_NBYTES;
    avail = (mq.size() > 0);
    vrise = v && !m_vp;
`ifdef DRBG_SER_LINE_KEY_EN
    hrise = h && !m_hp && !vrise;
`else
    hrise = 0;
`endif
    issue = !m_out && !busy && !vrise && (words < c_DEPTH);
    if (tk && !avail) m_uf = 1;
    if (vrise) begin
      mq.delete();
      if (m_out && dv) begin
        m_out = 0; m_disc = 0;
      end else if (m_out) begin
        m_disc = 1;
      end
    end else begin
      if (hrise) m_key = avail ? mq[0] : 8'h00;
      if ((tk || hrise) && avail) void'(mq.pop_front());
      if (dv && m_out) begin
        if (!m_disc) for (int k = 0; k < c_NBYTES; k++) mq.push_back(din[k*8 +: 8]);
        m_out = 0; m_disc = 0;
      end
    end
    if (issue) m_out = 1;
    m_need = issue;
    m_hp = h;
    m_vp = v;
  endfunction

  task automatic compare_model();
    chk("model_valid", data_out_valid, mq.size() > 0);
    chk("model_data", data_out, (mq.size() > 0) ? mq[0] : 8'h00);
    chk("model_need", need_next, m_need);
    chk("model_underflow", underflow, m_uf);
    chk("model_line_key", line_key, m_key);
  endtask

  // Called at a falling edge: apply inputs, settle, compare current outputs.
  task automatic drive(bit busy, bit tk, bit h, bit v, bit dv, logic [c_DW_IN-1:0] din);
    generator_busy = busy; take = tk; H = h; V = v;
    data_in_valid = dv; data_in = din;
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(generator_busy, take, H, V, data_in_valid, data_in);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    generator_busy = 0; take = 0; H = 0; V = 0; data_in_valid = 0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_need", need_next, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_key", line_key, 0);
    chk("rst_underflow", underflow, 0);
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    bit         busy, tk, dv;
    bit [1:0]   wsel;
    bit         e_need, e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t                tbl[8];
  logic [c_DW_IN-1:0]  w0, w1, rw;
  logic [c_DW_IN-1:0]  zw;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit rh, rv, rdv, pend;
    int dly;
    zw = '0;
    for (int k = 0; k < c_NBYTES; k++) begin
      w0[k*8 +: 8] = 8'(k + 1);
      w1[k*8 +: 8] = 8'(8'h40 + k);
    end
    //          busy tk dv wsel need valid data
    tbl[0] = '{0, 0, 0, 0, 0, 0, 8'h00};
    tbl[1] = '{0, 0, 0, 0, 1, 0, 8'h00};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 8'h00};
    tbl[3] = '{0, 1, 0, 0, 0, 1, 8'h01};
    tbl[4] = '{0, 1, 0, 0, 1, 1, 8'h02};
    tbl[5] = '{0, 0, 1, 2, 0, 1, 8'h03};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 8'h03};
    tbl[7] = '{1, 0, 0, 0, 0, 1, 8'h03};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].busy, tbl[i].tk, 0, 0, tbl[i].dv, (tbl[i].wsel == 2) ? w1 : w0);
      chk($sformatf("tbl%0d_need", i), need_next, tbl[i].e_need);
      chk($sformatf("tbl%0d_valid", i), data_out_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].e_data);
      tick();
    end

    // Drain first word with second buffered: no gap, no request while full.
    for (int i = 0; i < 30; i++) begin
      drive(0, 1, 0, 0, 0, zw);
      chk($sformatf("drain%0d_data", i), data_out, 32'(i + 3));
      chk($sformatf("drain%0d_need", i), need_next, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, zw);
    chk("second_word_valid", data_out_valid, 1);
    chk("second_word_data", data_out, 8'h40);
    chk("pop_need_low", need_next, 0);
    tick();
    drive(0, 0, 0, 0, 0, zw);
    chk("pop_need_pulse", need_next, 1);
    tick();
    drive(0, 0, 0, 0, 0, zw);
    chk("pop_need_single", need_next, 0);
    tick();

    // Field flush with a request outstanding.
    drive(0, 0, 0, 1, 0, zw);
    chk("flush_pre_valid", data_out_valid, 1);
    tick();
    drive(0, 0, 0, 1, 1, w0);
    chk("flush_valid", data_out_valid, 0);
    chk("flush_need", need_next, 0);
    tick();
    drive(0, 0, 0, 1, 0, zw);
    chk("discard_valid", data_out_valid, 0);
    tick();
    drive(0, 0, 0, 1, 0, zw);
    chk("post_flush_need", need_next, 1);
    chk("post_flush_valid", data_out_valid, 0);
    tick();
    drive(0, 0, 0, 1, 1, w1);
    tick();
    drive(0, 0, 0, 0, 0, zw);
    chk("refill_valid", data_out_valid, 1);
    chk("refill_data", data_out, 8'h40);
    tick();

    // Underflow is sticky until reset.
    do_reset();
    drive(1, 1, 0, 0, 0, zw);
    chk("uf_before", underflow, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, zw);
      chk($sformatf("uf_sticky%0d", i), underflow, 1);
      chk($sformatf("uf_nostate%0d", i), data_out_valid, 0);
      tick();
    end
    do_reset();

    // Reset mid-request; a late word must be ignored.
    drive(0, 0, 0, 0, 0, zw);
    tick();
    drive(0, 0, 0, 0, 0, zw);
    chk("midrst_need", need_next, 1);
    reset = 1'b1;
    #1;
    chk("midrst_async_need", need_next, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 1, w0);
    tick();
    drive(1, 0, 0, 0, 0, zw);
    chk("late_word_ignored", data_out_valid, 0);
    tick();

    // Line-start capture.
    do_reset();
    drive(0, 0, 0, 0, 0, zw); tick();
    drive(0, 0, 0, 0, 0, zw); tick();
    drive(1, 0, 0, 0, 1, w0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, zw); tick();
    end
    drive(1, 1, 1, 0, 0, zw);
    chk("hkey_pre_data", data_out, 8'h05);
    tick();
    drive(1, 0, 0, 0, 0, zw);
    chk("hkey_single_adv", data_out, 8'h06);
`ifdef DRBG_SER_LINE_KEY_EN
    chk("hkey_capture", line_key, 8'h05);
`else
    chk("hkey_tied0", line_key, 8'h00);
`endif
    tick();
    drive(1, 0, 1, 0, 0, zw);
    tick();
    drive(1, 0, 1, 0, 0, zw);
`ifdef DRBG_SER_LINE_KEY_EN
    chk("hrise_adv_data", data_out, 8'h07);
    chk("hrise_adv_key", line_key, 8'h06);
`else
    chk("hrise_ignored_data", data_out, 8'h06);
`endif
    tick();

    // Randomized traffic against the model.
    do_reset();
    rh = 0; rv = 0; pend = 0; dly = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset();
        rh = 0; rv = 0; pend = 0;
      end
      if ($urandom_range(0, 7) == 0) rh = !rh;
      if ($urandom_range(0, 39) == 0) rv = !rv;
      rdv = 0;
      rw = '0;
      if (pend && dly == 0) begin
        rdv = 1;
        pend = 0;
        for (int k = 0; k < 8; k++) rw[k*32 +: 32] = $urandom();
      end else begin
        if (pend) dly--;
        else if ($urandom_range(0, 15) == 0) begin
          rdv = 1;
          rw = {8{$urandom()}};
        end
      end
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rh, rv, rdv, rw);
      if (need_next) begin
        pend = 1;
        dly = $urandom_range(0, 3);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
